// File: rtl/sipo_deser_if.sv
// ---------------------------------------------------------------------------
// sipo_deser_if
//
// Purpose:
//   Bundles the serial input, the control inputs and the parallel output of
//   the sipo_deser deserializer into one interface.
//
// Signals:
//   shift         bit qualifier, serial_in is sampled only when shift=1
//   serial_in     serial data from the upstream piso serial_out
//   clr           synchronous abort of the partial word, clears overflow
//   out_ready     consumer accepts parallel_out when out_valid=1
//   parallel_out  assembled word, stable while out_valid=1
//   out_valid     word available
//   overflow      sticky flag, a completed word was dropped
//   bit_cnt       bits collected in the current partial word
//
// Modports:
//   master  the side that feeds bits and consumes words
//   slave   the deserializer itself
// ---------------------------------------------------------------------------
interface sipo_deser_if #(
  parameter int width = 4
) ();

  localparam int cnt_w = $clog2(width);

  logic             shift;
  logic             serial_in;
  logic             clr;
  logic             out_ready;
  logic [width-1:0] parallel_out;
  logic             out_valid;
  logic             overflow;
  logic [cnt_w-1:0] bit_cnt;

  modport master (
    output shift,
    output serial_in,
    output clr,
    output out_ready,
    input  parallel_out,
    input  out_valid,
    input  overflow,
    input  bit_cnt
  );

  modport slave (
    input  shift,
    input  serial_in,
    input  clr,
    input  out_ready,
    output parallel_out,
    output out_valid,
    output overflow,
    output bit_cnt
  );

endinterface

// File: rtl/sipo_deser.sv
// ---------------------------------------------------------------------------
// sipo_deser
//
// Purpose:
//   Serial-in, parallel-out deserializer. Collects `width` qualified bits of
//   serial_in into a word, presents the word with a valid/ready handshake and
//   raises a sticky overflow flag when a completed word has to be dropped
//   because the previous one is still waiting for the consumer.
//
// Parameters:
//   width      bits per word (>= 2)
//   msb_first  1: first received bit ends up in parallel_out[width-1]
//              0: first received bit ends up in parallel_out[0]
//
// Ports:
//   clk   system clock, rising edge active
//   rst   asynchronous active-high reset
//   bus   sipo_deser_if slave modport (shift, serial_in, clr, out_ready in;
//         parallel_out, out_valid, overflow, bit_cnt out)
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module sipo_deser #(
  parameter int width     = 4,
  parameter bit msb_first = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  sipo_deser_if.slave  bus
);

  localparam int cnt_w = $clog2(width);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(width - 1);

  // EMPTY: no word held for the consumer, FULL: parallel_out is valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg,    state_next;
  logic [width-1:0] shift_reg,    shift_next;
  logic [cnt_w-1:0] bit_cnt_reg,  bit_cnt_next;
  logic [width-1:0] word_reg,     word_next;
  logic             overflow_reg, overflow_next;

  // Shift register contents after taking in the current serial_in bit.
  logic [width-1:0] assembled;
  logic             complete;
  logic             transfer;

  // -------------------------------------------------------------------------
  // Bit placement. For MSB-first the register moves towards the top and the
  // new bit enters at bit 0; for LSB-first it moves towards bit 0 and the new
  // bit enters at the top, so after `width` bits the first one sits at bit 0.
  // -------------------------------------------------------------------------
  generate
    genvar gi;
    if (msb_first) begin : g_msb
      assign assembled[0] = bus.serial_in;
      for (gi = 1; gi < width; gi++) begin : g_bit
        assign assembled[gi] = shift_reg[gi-1];
      end
    end else begin : g_lsb
      assign assembled[width-1] = bus.serial_in;
      for (gi = 0; gi < width - 1; gi++) begin : g_bit
        assign assembled[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  // A word completes when its last bit is sampled. clr suppresses sampling,
  // so no word can complete on a clr cycle.
  assign complete = bus.shift && !bus.clr && (bit_cnt_reg == last_cnt);

  // The handshake depends only on registered state plus out_ready, so
  // out_ready is naturally ignored while nothing is held.
  assign transfer = (state_reg == FULL) && bus.out_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      word_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      word_reg     <= word_next;
      overflow_reg <= overflow_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_next     = word_reg;
    overflow_next = overflow_reg;

    // Collection side. clr aborts the partial word but leaves the output
    // side alone, so a pending word survives it.
    if (bus.clr) begin
      shift_next    = '0;
      bit_cnt_next  = '0;
      overflow_next = 1'b0;
    end else if (bus.shift) begin
      shift_next = assembled;
      if (complete) begin
        bit_cnt_next = '0;
      end else begin
        bit_cnt_next = bit_cnt_reg + cnt_w'(1);
      end
    end

    // Output side.
    case (state_reg)
      EMPTY: begin
        if (complete) begin
          word_next  = assembled;
          state_next = FULL;
        end
      end
      FULL: begin
        if (transfer) begin
          // The slot frees up on this edge, so a word completing now can
          // take it directly without a bubble.
          if (complete) begin
            word_next = assembled;
          end else begin
            state_next = EMPTY;
          end
        end else if (complete) begin
          // Consumer still holds off: the new word is lost, the old one
          // stays on parallel_out.
          overflow_next = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.parallel_out = word_reg;
  assign bus.out_valid    = (state_reg == FULL);
  assign bus.overflow     = overflow_reg;
  assign bus.bit_cnt      = bit_cnt_reg;

endmodule

// File: tb/tb_sipo_deser.sv
// ---------------------------------------------------------------------------
// tb_sipo_deser
//
// Two deserializer instances (MSB-first and LSB-first, width 4) share one
// stimulus path; `sel` chooses which one is driven and observed while the
// other sits idle. Completed words are pushed to a scoreboard queue when the
// last bit is driven and popped/compared when the handshake takes them.
// ---------------------------------------------------------------------------
module tb_sipo_deser;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sipo_deser_if #(.width(W)) bm ();
  sipo_deser_if #(.width(W)) bl ();

  sipo_deser #(.width(W), .msb_first(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bm.slave)
  );

  sipo_deser #(.width(W), .msb_first(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bl.slave)
  );

  // Shared drive, gated per instance by sel.
  bit sel = 1'b0;
  bit d_shift = 1'b0;
  bit d_sin   = 1'b0;
  bit d_clr   = 1'b0;
  bit d_ready = 1'b0;

  assign bm.shift     = d_shift & ~sel;
  assign bm.serial_in = d_sin;
  assign bm.clr       = d_clr & ~sel;
  assign bm.out_ready = d_ready & ~sel;
  assign bl.shift     = d_shift & sel;
  assign bl.serial_in = d_sin;
  assign bl.clr       = d_clr & sel;
  assign bl.out_ready = d_ready & sel;

  logic [W-1:0] o_word;
  logic         o_valid;
  logic         o_ovf;
  logic [1:0]   o_cnt;

  assign o_word  = sel ? bl.parallel_out : bm.parallel_out;
  assign o_valid = sel ? bl.out_valid    : bm.out_valid;
  assign o_ovf   = sel ? bl.overflow     : bm.overflow;
  assign o_cnt   = sel ? bl.bit_cnt      : bm.bit_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model of the observed instance.
  bit           m_bits[$];
  bit           m_full = 1'b0;
  bit           m_ovf  = 1'b0;
  logic [W-1:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word implied by the collected bits, placed by arrival order.
  function automatic logic [W-1:0] build_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (!sel) w[W-1-i] = m_bits[i];
      else      w[i]     = m_bits[i];
    end
    return w;
  endfunction

  // One clock: drive inputs, predict, advance, compare.
  task automatic step(input bit s, input bit b, input bit c, input bit r);
    bit           hs;
    bit           complete;
    logic [W-1:0] w;
    logic [W-1:0] exp_w;
    d_shift = s;
    d_sin   = b;
    d_clr   = c;
    d_ready = r;
    hs       = m_full && r;
    complete = 1'b0;
    w        = '0;
    if (hs) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got handshake expected none at %0t", $time);
      end else begin
        exp_w = sb_q.pop_front();
        check("sb_word", 32'(o_word), 32'(exp_w));
      end
    end
    if (c) begin
      m_bits.delete();
      m_ovf = 1'b0;
    end else if (s) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        w = build_word();
        m_bits.delete();
        complete = 1'b1;
      end
    end
    if (complete && (!m_full || hs)) begin
      sb_q.push_back(w);
      m_full = 1'b1;
    end else if (complete) begin
      m_ovf = 1'b1;
    end else if (hs) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(o_valid), 32'(m_full));
    check("overflow", 32'(o_ovf), 32'(m_ovf));
    check("bit_cnt", 32'(o_cnt), 32'(m_bits.size()));
    $display("step sel=%0d shift=%0d in=%0d clr=%0d rdy=%0d -> word=%b valid=%0d ovf=%0d cnt=%0d",
             sel, s, b, c, r, o_word, o_valid, o_ovf, o_cnt);
  endtask

  task automatic model_clear();
    m_bits.delete();
    m_full = 1'b0;
    m_ovf  = 1'b0;
    sb_q.delete();
  endtask

  // Reset applied between edges, held across one edge, released off-edge.
  task automatic do_reset();
    d_shift = 1'b0;
    d_clr   = 1'b0;
    d_ready = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit           s;
    bit           b;
    bit           c;
    bit           r;
    bit           ev;
    bit           eo;
    int           ec;
    logic [W-1:0] ew;
  } vec_t;

  vec_t bp_tab[10];

  initial begin
    // Back-pressure / overflow sequence for the MSB-first instance.
    bp_tab[0] = '{1, 1, 0, 0, 0, 0, 1, 4'b0000};
    bp_tab[1] = '{1, 0, 0, 0, 0, 0, 2, 4'b0000};
    bp_tab[2] = '{1, 0, 0, 0, 0, 0, 3, 4'b0000};
    bp_tab[3] = '{1, 1, 0, 0, 1, 0, 0, 4'b1001};
    bp_tab[4] = '{1, 0, 0, 0, 1, 0, 1, 4'b1001};
    bp_tab[5] = '{1, 1, 0, 0, 1, 0, 2, 4'b1001};
    bp_tab[6] = '{1, 1, 0, 0, 1, 0, 3, 4'b1001};
    bp_tab[7] = '{1, 0, 0, 0, 1, 1, 0, 4'b1001};
    bp_tab[8] = '{0, 0, 0, 1, 0, 1, 0, 4'b1001};
    bp_tab[9] = '{0, 0, 1, 0, 0, 0, 0, 4'b1001};

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_msb", 32'(bm.out_valid), 32'd0);
    check("rst_word_msb", 32'(bm.parallel_out), 32'd0);
    check("rst_ovf_msb", 32'(bm.overflow), 32'd0);
    check("rst_cnt_msb", 32'(bm.bit_cnt), 32'd0);
    check("rst_valid_lsb", 32'(bl.out_valid), 32'd0);
    check("rst_word_lsb", 32'(bl.parallel_out), 32'd0);
    rst = 1'b0;
    model_clear();

    // 1. Reset mid-word takes effect without waiting for an edge.
    sel = 1'b0;
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt", 32'(o_cnt), 32'd0);
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_word", 32'(o_word), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_clear();
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("post_rst_word", 32'(o_word), 32'h9);

    // 2. Loopback from a piso loaded with 1001, out_ready held high.
    do_reset();
    begin
      logic [W-1:0] piso_reg;
      piso_reg = 4'b1001;
      for (int i = 0; i < W; i++) begin
        step(1, piso_reg[W-1], 0, 1);
        piso_reg = {piso_reg[W-2:0], 1'b0};
        if (i < W - 1) check("loop_valid_early", 32'(o_valid), 32'd0);
      end
    end
    check("loop_valid", 32'(o_valid), 32'd1);
    check("loop_word", 32'(o_word), 32'h9);
    check("loop_ovf", 32'(o_ovf), 32'd0);
    step(0, 0, 0, 1);
    check("loop_pulse_end", 32'(o_valid), 32'd0);

    // 3. LSB-first ordering.
    do_reset();
    sel = 1'b1;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("lsb_word", 32'(o_word), 32'h3);
    check("lsb_valid", 32'(o_valid), 32'd1);

    // 4. Back-pressure, overflow, drain, clr (table driven).
    do_reset();
    sel = 1'b0;
    foreach (bp_tab[i]) begin
      step(bp_tab[i].s, bp_tab[i].b, bp_tab[i].c, bp_tab[i].r);
      check($sformatf("bp%0d_valid", i), 32'(o_valid), 32'(bp_tab[i].ev));
      check($sformatf("bp%0d_ovf", i), 32'(o_ovf), 32'(bp_tab[i].eo));
      check($sformatf("bp%0d_cnt", i), 32'(o_cnt), 32'(bp_tab[i].ec));
      check($sformatf("bp%0d_word", i), 32'(o_word), 32'(bp_tab[i].ew));
    end

    // 5. Accept and complete on the same edge.
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("sim_w1", 32'(o_word), 32'hC);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    check("sim_w2", 32'(o_word), 32'hA);
    check("sim_valid", 32'(o_valid), 32'd1);
    check("sim_ovf", 32'(o_ovf), 32'd0);
    step(0, 0, 0, 0);
    check("sim_hold", 32'(o_word), 32'hA);

    // 6. Gapped shift, then clr abort of a partial word.
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("gap_word", 32'(o_word), 32'h5);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    check("clr_keeps_xfer", 32'(o_valid), 32'd0);
    check("clr_cnt", 32'(o_cnt), 32'd0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("clr_word", 32'(o_word), 32'hF);

    // Random traffic on both orderings against the scoreboard.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      sel = (pass == 1);
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0,
             1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
